// File: rtl/reaction_timer_ctrl.sv
// reaction_timer_ctrl: top-level sequencer for the reaction-timer game.
// Derives ms and light-tick timing from clk, builds the start lights while the
// LFSR runs, holds for a random delay, then times the player's response in ms.
// Optional JUMP_START_EN: early response in LIGHTS/HOLD enters a FAULT state.
module reaction_timer_ctrl #(
  parameter int unsigned CLK_PER_MS   = 50000,
  parameter int unsigned MS_PER_TICK  = 500,
  parameter int unsigned N_LEDS       = 10,
  parameter int unsigned MIN_DELAY_MS = 250,
  parameter int unsigned MAX_MS       = 9999
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trigger,
  input  logic              response,
  input  logic [13:0]       lfsr_val,
  output logic              lfsr_en,
  output logic [N_LEDS-1:0] ledr,
  output logic [13:0]       result_ms,
  output logic              result_valid,
  output logic              busy,
  output logic              jump_start
);

  localparam int unsigned PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam int unsigned TW = (MS_PER_TICK > 1) ? $clog2(MS_PER_TICK) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_PER_MS - 1);
  localparam logic [TW-1:0] TICK_LAST  = TW'(MS_PER_TICK - 1);
  localparam logic [13:0]   COUNT_MAX  = 14'(MAX_MS);
  localparam logic [14:0]   DELAY_MIN  = 15'(MIN_DELAY_MS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LIGHTS,
    S_HOLD,
    S_GO,
    S_DONE
`ifdef JUMP_START_EN
    , S_FAULT
`endif
  } state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic [TW-1:0]     tick_q, tick_d;
  logic [14:0]       delay_q, delay_d;
  logic [13:0]       count_q, count_d;
  logic [N_LEDS-1:0] ledr_q, ledr_d;
  logic [13:0]       result_q, result_d;
  logic              valid_q, valid_d;
  logic              trig_prev_q, trig_prev_d;
  logic              resp_prev_q, resp_prev_d;

  logic trig_edge;
  logic resp_edge;
  logic ms_strobe;

  assign trig_edge = trigger & ~trig_prev_q;
  assign resp_edge = response & ~resp_prev_q;
  assign ms_strobe = (presc_q == PRESC_LAST);

  // Next-state, timing counters and registered outputs.
  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q;
    delay_d     = delay_q;
    count_d     = count_q;
    ledr_d      = ledr_q;
    result_d    = result_q;
    valid_d     = valid_q;
    trig_prev_d = trigger;
    resp_prev_d = response;

    case (state_q)
      S_IDLE: begin
        if (trig_edge) begin
          state_d = S_LIGHTS;
          ledr_d  = '0;
          tick_d  = '0;
        end
      end
      S_LIGHTS: begin
`ifdef JUMP_START_EN
        if (resp_edge) begin
          state_d = S_FAULT;
          ledr_d  = '1;
        end else
`endif
        if (ms_strobe) begin
          if (tick_q == TICK_LAST) begin
            tick_d = '0;
            ledr_d = {ledr_q[N_LEDS-2:0], 1'b1};
            // Last light: latch the random hold delay in the same cycle.
            if (ledr_q[N_LEDS-2]) begin
              delay_d = {1'b0, lfsr_val} + DELAY_MIN;
              state_d = S_HOLD;
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      S_HOLD: begin
`ifdef JUMP_START_EN
        if (resp_edge) begin
          state_d = S_FAULT;
          ledr_d  = '1;
        end else
`endif
        if (ms_strobe) begin
          if (delay_q <= 15'd1) begin
            ledr_d  = '0;
            count_d = '0;
            state_d = S_GO;
          end else begin
            delay_d = delay_q - 15'd1;
          end
        end
      end
      S_GO: begin
        if (resp_edge) begin
          result_d = count_q;
          valid_d  = 1'b1;
          state_d  = S_DONE;
        end else if (ms_strobe && (count_q != COUNT_MAX)) begin
          count_d = count_q + 14'd1;
        end
      end
      S_DONE: begin
        if (trig_edge) begin
          state_d = S_LIGHTS;
          valid_d = 1'b0;
          ledr_d  = '0;
          tick_d  = '0;
        end
      end
`ifdef JUMP_START_EN
      S_FAULT: begin
        if (trig_edge) begin
          state_d = S_LIGHTS;
          ledr_d  = '0;
          tick_d  = '0;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // Prescaler restarts on every state change so each state's first ms is full.
    if ((state_d != state_q) || ms_strobe) presc_d = '0;
    else                                   presc_d = presc_q + PW'(1);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      presc_q     <= '0;
      tick_q      <= '0;
      delay_q     <= '0;
      count_q     <= '0;
      ledr_q      <= '0;
      result_q    <= '0;
      valid_q     <= 1'b0;
      trig_prev_q <= 1'b1;
      resp_prev_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      tick_q      <= tick_d;
      delay_q     <= delay_d;
      count_q     <= count_d;
      ledr_q      <= ledr_d;
      result_q    <= result_d;
      valid_q     <= valid_d;
      trig_prev_q <= trig_prev_d;
      resp_prev_q <= resp_prev_d;
    end
  end

  assign lfsr_en      = (state_q == S_LIGHTS);
  assign busy         = (state_q == S_LIGHTS) || (state_q == S_HOLD) || (state_q == S_GO);
  assign ledr         = ledr_q;
  assign result_ms    = result_q;
  assign result_valid = valid_q;
`ifdef JUMP_START_EN
  assign jump_start   = (state_q == S_FAULT);
`else
  assign jump_start   = 1'b0;
`endif

endmodule
